// File: rtl/fc_feature_streamer_if.sv
// Handshake and FC-side signal bundle for the feature streamer.
// Slave is the streamer; master is the producer/FC side.
interface fc_feature_streamer_if #(
    parameter int I_BW = 32,
    parameter int CI   = 3
);
    logic                 i_valid;
    logic                 o_ready;
    logic [CI*I_BW-1:0]   i_data;
    logic                 o_fc_rst;
    logic                 o_fc_ce;
    logic [CI*I_BW-1:0]   o_fc_data;
    logic                 i_fc_done;
    logic [3:0]           i_fc_class;
    logic [3:0]           o_class;
    logic                 o_class_valid;
    logic                 o_busy;
    logic                 o_timeout;

    modport master (
        output i_valid, i_data, i_fc_done, i_fc_class,
        input  o_ready, o_fc_rst, o_fc_ce, o_fc_data,
        input  o_class, o_class_valid, o_busy, o_timeout
    );

    modport slave (
        input  i_valid, i_data, i_fc_done, i_fc_class,
        output o_ready, o_fc_rst, o_fc_ce, o_fc_data,
        output o_class, o_class_valid, o_busy, o_timeout
    );
endinterface

// File: rtl/fc_feature_streamer.sv
// Buffers one feature-map frame, replays it into an FC layer,
// then waits for the FC class result or a timeout.
module fc_feature_streamer #(
    parameter int I_BW    = 32,
    parameter int CI      = 3,
    parameter int IF_SIZE = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    fc_feature_streamer_if.slave  bus
);
    localparam int N  = IF_SIZE * IF_SIZE;
    localparam int W  = CI * I_BW;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (TW > 7) ? TW : 7;

    typedef enum logic [1:0] {
        S_FILL,
        S_CLEAR,
        S_STREAM,
        S_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   wr_q, wr_d;
    logic [IW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            fc_rst_q, fc_rst_d;
    logic            ce_q, ce_d;
    logic [W-1:0]    data_q, data_d;
    logic [3:0]      cls_q, cls_d;
    logic            cls_vld_q, cls_vld_d;
    logic            tmo_q, tmo_d;
    logic [W-1:0]    buf_q [N];
    logic            accept;

    assign accept = (state_q == S_FILL) && ready_q && bus.i_valid;

    // Frame storage carries no reset; contents are rewritten each frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[wr_q] <= bus.i_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        fc_rst_d  = 1'b0;
        ce_d      = 1'b0;
        data_d    = '0;
        cls_d     = cls_q;
        cls_vld_d = 1'b0;
        tmo_d     = tmo_q;
        unique case (state_q)
            S_FILL: begin
                ready_d = 1'b1;
                if (accept) begin
                    if (wr_q == '0) begin
                        tmo_d = 1'b0;
                    end
                    if (wr_q == IW'(N - 1)) begin
                        wr_d     = '0;
                        ready_d  = 1'b0;
                        fc_rst_d = 1'b1;
                        state_d  = S_CLEAR;
                    end else begin
                        wr_d = wr_q + IW'(1);
                    end
                end
            end
            S_CLEAR: begin
                rd_d    = '0;
                ce_d    = 1'b1;
                data_d  = buf_q[0];
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (rd_q == IW'(N - 1)) begin
                    rd_d    = '0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    rd_d   = rd_q + IW'(1);
                    ce_d   = 1'b1;
                    data_d = buf_q[rd_q + IW'(1)];
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A done arriving on the timeout cycle still wins.
                if (bus.i_fc_done) begin
                    cls_d     = bus.i_fc_class;
                    cls_vld_d = 1'b1;
                    cnt_d     = '0;
                    ready_d   = 1'b1;
                    state_d   = S_FILL;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
        busy_d = ~ready_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FILL;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            fc_rst_q  <= 1'b0;
            ce_q      <= 1'b0;
            data_q    <= '0;
            cls_q     <= '0;
            cls_vld_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            fc_rst_q  <= fc_rst_d;
            ce_q      <= ce_d;
            data_q    <= data_d;
            cls_q     <= cls_d;
            cls_vld_q <= cls_vld_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.o_ready       = ready_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_fc_rst      = fc_rst_q;
    assign bus.o_fc_ce       = ce_q;
    assign bus.o_fc_data     = data_q;
    assign bus.o_class       = cls_q;
    assign bus.o_class_valid = cls_vld_q;
    assign bus.o_timeout     = tmo_q;
endmodule

// File: tb/tb_fc_feature_streamer.sv
// Scoreboard bench for fc_feature_streamer: stimulus queues expected
// stream words and classes, a negedge monitor pops and compares.
module tb_fc_feature_streamer;
    localparam int I_BW = 32;
    localparam int CI   = 3;
    localparam int N    = 16;
    localparam int W    = CI * I_BW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fc_feature_streamer_if #(.I_BW(I_BW), .CI(CI)) bus ();

    fc_feature_streamer #(
        .I_BW(I_BW), .CI(CI), .IF_SIZE(4), .TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q [$];
    logic [3:0]   cls_exp [$];

    task automatic check(string name, logic [127:0] act,
                         logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] word(int k);
        return {32'(k + 2), 32'(k + 1), 32'(k)};
    endfunction

    // Monitor: stream words, class pulses, idle data, busy/ready.
    int   run = 0;
    logic vld_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst !== 1'b0) begin
            run      = 0;
            vld_prev = 1'b0;
        end else begin
            check("busy_xor_ready", 128'(bus.o_busy ^ bus.o_ready), 1);
            if (bus.o_fc_ce) begin
                run++;
                check("ce_run_le_n", 128'(run <= N), 1);
                check("stream_expected", 128'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0)
                    check("stream_word", bus.o_fc_data, exp_q.pop_front());
            end else begin
                run = 0;
                check("data_idle_zero", bus.o_fc_data, 0);
            end
            if (bus.o_class_valid) begin
                check("class_vld_1cyc", 128'(vld_prev), 0);
                check("class_expected", 128'(cls_exp.size() > 0), 1);
                if (cls_exp.size() > 0)
                    check("class_value", bus.o_class, cls_exp.pop_front());
            end
            vld_prev = bus.o_class_valid;
        end
    end

    task automatic send_frame(int base, bit gap, bit hold);
        for (int k = 0; k < N; k++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = word(base + k);
            exp_q.push_back(word(base + k));
            @(posedge clk);
            #1;
            if (k == 0) check("timeout_clear", 128'(bus.o_timeout), 0);
            if (gap && k != N - 1) begin
                bus.i_valid = 1'b0;
                bus.i_data  = word(900 + k);
                @(posedge clk);
                #1;
            end
        end
        bus.i_valid = hold;
        bus.i_data  = word(1000 + base);
    endtask

    task automatic run_stream(int abort_at);
        @(negedge clk);
        check("clear_fc_rst", 128'(bus.o_fc_rst), 1);
        check("clear_ce", 128'(bus.o_fc_ce), 0);
        check("clear_ready", 128'(bus.o_ready), 0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("stream_ce", 128'(bus.o_fc_ce), 1);
            check("stream_fc_rst", 128'(bus.o_fc_rst), 0);
            if (i == N - 1) begin
                bus.i_valid   = 1'b0;
                bus.i_fc_done = 1'b0;
            end
            if (i == abort_at) begin
                #2 rst = 1'b1;
                exp_q.delete();
                #1;
                check("rst_ce", 128'(bus.o_fc_ce), 0);
                check("rst_data", bus.o_fc_data, 0);
                check("rst_ready", 128'(bus.o_ready), 0);
                check("rst_busy", 128'(bus.o_busy), 0);
                return;
            end
        end
        @(negedge clk);
        check("wait_ce_low", 128'(bus.o_fc_ce), 0);
        check("wait_busy", 128'(bus.o_busy), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst            = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_data     = '0;
        bus.i_fc_done  = 1'b0;
        bus.i_fc_class = 4'd0;
        #1 rst = 1'b1;
        #2;
        check("rst_ready0", 128'(bus.o_ready), 0);
        check("rst_busy0", 128'(bus.o_busy), 0);
        check("rst_ce0", 128'(bus.o_fc_ce), 0);
        check("rst_fcrst0", 128'(bus.o_fc_rst), 0);
        check("rst_data0", bus.o_fc_data, 0);
        check("rst_class0", 128'(bus.o_class), 0);
        check("rst_clsvld0", 128'(bus.o_class_valid), 0);
        check("rst_tmo0", 128'(bus.o_timeout), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", 128'(bus.o_ready), 1);
        check("busy_after_rst", 128'(bus.o_busy), 0);

        // Frame A: plain stream, done with class 7 six cycles in.
        send_frame(0, 1'b0, 1'b0);
        run_stream(-1);
        repeat (5) @(posedge clk);
        #1;
        bus.i_fc_done  = 1'b1;
        bus.i_fc_class = 4'd7;
        cls_exp.push_back(4'd7);
        @(posedge clk);
        #1;
        bus.i_fc_done = 1'b0;
        check("done_ready", 128'(bus.o_ready), 1);
        check("done_class", 128'(bus.o_class), 7);
        check("done_no_tmo", 128'(bus.o_timeout), 0);

        // Frame B: gapped input, valid held and stray done pulses.
        bus.i_fc_done  = 1'b1;
        bus.i_fc_class = 4'd3;
        send_frame(20, 1'b1, 1'b1);
        run_stream(-1);
        cnt = 0;
        while (!bus.o_timeout && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_cycles", 128'(cnt), 64);
        check("timeout_flag", 128'(bus.o_timeout), 1);
        check("timeout_class", 128'(bus.o_class), 7);
        check("timeout_ready", 128'(bus.o_ready), 1);

        // Frame C: reset in the middle of the stream.
        send_frame(40, 1'b0, 1'b0);
        run_stream(5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (!bus.o_ready && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("ready_after_abort", 128'(bus.o_ready), 1);
        check("class_after_abort", 128'(bus.o_class), 0);
        check("tmo_after_abort", 128'(bus.o_timeout), 0);

        // Frame D: fresh frame, done on the first wait cycle.
        send_frame(60, 1'b0, 1'b0);
        run_stream(-1);
        bus.i_fc_done  = 1'b1;
        bus.i_fc_class = 4'd9;
        cls_exp.push_back(4'd9);
        @(posedge clk);
        #1;
        bus.i_fc_done = 1'b0;
        check("done2_class", 128'(bus.o_class), 9);
        check("done2_ready", 128'(bus.o_ready), 1);

        repeat (3) @(negedge clk);
        check("words_drained", 128'(exp_q.size()), 0);
        check("classes_drained", 128'(cls_exp.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
